// File: rtl/nic_link_scheduler.sv
// Per-VC credit-based link scheduler: FREE/ACTIVE/DRAINING tracking, round-robin flit grant.
// Optional macro NIC_LINK_SCHEDULER_PACKET_LOCK_EN holds arbitration on a VC until its tail flit is granted.
module nic_link_scheduler #(
  parameter int N_TOT_OF_VC   = 6,
  parameter int N_BITS_VC_ID  = 3,
  parameter int BUFFER_DEPTH  = 4,
  parameter int N_BITS_CREDIT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_TOT_OF_VC-1:0]  va_grant_i,
  input  logic [N_TOT_OF_VC-1:0]  r_sa_i,
  input  logic [N_TOT_OF_VC-1:0]  tail_i,
  input  logic [N_TOT_OF_VC-1:0]  credit_i,
  output logic [N_TOT_OF_VC-1:0]  g_sa_o,
  output logic                    flit_valid_o,
  output logic [N_BITS_VC_ID-1:0] vc_id_o,
  output logic [N_TOT_OF_VC-1:0]  fifo_pointer_state_o,
  output logic                    credit_err_o
);

  typedef enum logic [1:0] {
    VC_FREE     = 2'b00,
    VC_ACTIVE   = 2'b01,
    VC_DRAINING = 2'b10
  } vc_state_t;

  localparam logic [N_BITS_CREDIT-1:0] FULL_CREDIT = N_BITS_CREDIT'(BUFFER_DEPTH);
  localparam logic [N_BITS_CREDIT-1:0] ONE_CREDIT  = N_BITS_CREDIT'(1);
  localparam logic [N_BITS_CREDIT-1:0] NO_CREDIT   = {N_BITS_CREDIT{1'b0}};
  localparam logic [N_BITS_VC_ID-1:0]  LAST_VC     = N_BITS_VC_ID'(N_TOT_OF_VC - 1);
  localparam logic [N_BITS_VC_ID-1:0]  VC_ZERO     = {N_BITS_VC_ID{1'b0}};

  vc_state_t                state_r      [N_TOT_OF_VC];
  vc_state_t                state_nxt_s  [N_TOT_OF_VC];
  logic [N_BITS_CREDIT-1:0] credit_r     [N_TOT_OF_VC];
  logic [N_BITS_CREDIT-1:0] credit_nxt_s [N_TOT_OF_VC];
  logic [N_BITS_VC_ID-1:0]  rr_ptr_r;
  logic                     credit_err_r;
  logic                     overflow_s;
  logic [N_TOT_OF_VC-1:0]   elig_s;
  logic [N_TOT_OF_VC-1:0]   grant_s;
  logic [N_TOT_OF_VC-1:0]   busy_s;
  logic                     rr_vld_s;
  logic [N_BITS_VC_ID-1:0]  rr_idx_s;
  logic                     grant_vld_s;
  logic [N_BITS_VC_ID-1:0]  grant_idx_s;
`ifdef NIC_LINK_SCHEDULER_PACKET_LOCK_EN
  logic                     lock_r;
  logic [N_BITS_VC_ID-1:0]  lock_vc_r;
`endif

  // Eligibility uses the registered counter, so a same-cycle credit return cannot unblock a VC
  always_comb begin
    elig_s = {N_TOT_OF_VC{1'b0}};
    busy_s = {N_TOT_OF_VC{1'b0}};
    for (int i = 0; i < N_TOT_OF_VC; i++) begin
      elig_s[i] = (state_r[i] == VC_ACTIVE) && r_sa_i[i] && (credit_r[i] != NO_CREDIT);
      busy_s[i] = (state_r[i] != VC_FREE);
    end
  end

  // Round-robin search starting one past the last granted VC
  always_comb begin
    int                      cand_int;
    logic [N_BITS_VC_ID-1:0] cand_s;
    logic                    hit_s;
    rr_vld_s = 1'b0;
    rr_idx_s = VC_ZERO;
    cand_int = 0;
    cand_s   = VC_ZERO;
    hit_s    = 1'b0;
    for (int k = 1; k <= N_TOT_OF_VC; k++) begin
      cand_int = int'(rr_ptr_r) + k;
      cand_int = (cand_int >= N_TOT_OF_VC) ? cand_int - N_TOT_OF_VC : cand_int;
      cand_s   = N_BITS_VC_ID'(cand_int);
      hit_s    = !rr_vld_s && elig_s[cand_s];
      rr_idx_s = hit_s ? cand_s : rr_idx_s;
      rr_vld_s = rr_vld_s | hit_s;
    end
  end

  // Final grant choice: round-robin result, overridden by an open packet lock when enabled
  always_comb begin
    grant_vld_s = rr_vld_s;
    grant_idx_s = rr_idx_s;
`ifdef NIC_LINK_SCHEDULER_PACKET_LOCK_EN
    if (lock_r) begin
      grant_vld_s = elig_s[lock_vc_r];
      grant_idx_s = elig_s[lock_vc_r] ? lock_vc_r : VC_ZERO;
    end else begin
      grant_vld_s = rr_vld_s;
      grant_idx_s = rr_idx_s;
    end
`endif
  end

  // One-hot decode of the winning VC
  always_comb begin
    grant_s = {N_TOT_OF_VC{1'b0}};
    for (int i = 0; i < N_TOT_OF_VC; i++) begin
      grant_s[i] = grant_vld_s && (grant_idx_s == N_BITS_VC_ID'(i));
    end
  end

  // Credit bookkeeping and per-VC next state
  always_comb begin
    overflow_s = 1'b0;
    for (int i = 0; i < N_TOT_OF_VC; i++) begin
      credit_nxt_s[i] = credit_r[i];
      state_nxt_s[i]  = state_r[i];
      if (grant_s[i] && !credit_i[i]) begin
        credit_nxt_s[i] = credit_r[i] - ONE_CREDIT;
      end else if (!grant_s[i] && credit_i[i]) begin
        if (credit_r[i] == FULL_CREDIT) begin
          overflow_s = 1'b1;
        end else begin
          credit_nxt_s[i] = credit_r[i] + ONE_CREDIT;
        end
      end else begin
        credit_nxt_s[i] = credit_r[i];
      end
      case (state_r[i])
        VC_FREE:     state_nxt_s[i] = va_grant_i[i] ? VC_ACTIVE : VC_FREE;
        VC_ACTIVE:   state_nxt_s[i] = (grant_s[i] && tail_i[i]) ? VC_DRAINING : VC_ACTIVE;
        VC_DRAINING: state_nxt_s[i] = (credit_nxt_s[i] == FULL_CREDIT) ? VC_FREE : VC_DRAINING;
        default:     state_nxt_s[i] = VC_FREE;
      endcase
    end
  end

  // Per-VC state and credit registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_TOT_OF_VC; i++) begin
        state_r[i]  <= VC_FREE;
        credit_r[i] <= FULL_CREDIT;
      end
    end else begin
      for (int i = 0; i < N_TOT_OF_VC; i++) begin
        state_r[i]  <= state_nxt_s[i];
        credit_r[i] <= credit_nxt_s[i];
      end
    end
  end

  // Round-robin pointer moves only when a flit was granted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_r <= LAST_VC;
    end else if (grant_vld_s) begin
      rr_ptr_r <= grant_idx_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Sticky credit overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_err_r <= 1'b0;
    end else if (overflow_s) begin
      credit_err_r <= 1'b1;
    end else begin
      credit_err_r <= credit_err_r;
    end
  end

`ifdef NIC_LINK_SCHEDULER_PACKET_LOCK_EN
  // Lock opens on a non-tail grant and closes when that VC's tail is granted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_r    <= 1'b0;
      lock_vc_r <= VC_ZERO;
    end else if (grant_vld_s) begin
      lock_r    <= !tail_i[grant_idx_s];
      lock_vc_r <= grant_idx_s;
    end else begin
      lock_r    <= lock_r;
      lock_vc_r <= lock_vc_r;
    end
  end
`endif

  assign g_sa_o               = grant_s;
  assign flit_valid_o         = grant_vld_s;
  assign vc_id_o              = grant_idx_s;
  assign fifo_pointer_state_o = busy_s;
  assign credit_err_o         = credit_err_r;

endmodule

// File: tb/tb_nic_link_scheduler.sv
// Self-checking bench for nic_link_scheduler: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_nic_link_scheduler;
  localparam int N = 6;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] va_grant = '0, r_sa = '0, tail = '0, credit = '0;
  logic [N-1:0] g_sa, busy;
  logic         flit_valid, credit_err;
  logic [2:0]   vc_id;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit m_active [N];
  bit m_drain  [N];
  int m_cred   [N];
  int m_last;
  bit m_err;
  bit m_lock;
  int m_lock_vc;
  int exp_g;

  logic [N-1:0] obs_g, obs_busy;
  logic [2:0]   obs_id;
  logic         obs_err;

  always #5 clk = ~clk;

  nic_link_scheduler #(
    .N_TOT_OF_VC(N), .N_BITS_VC_ID(3), .BUFFER_DEPTH(D), .N_BITS_CREDIT(3)
  ) dut (
    .clk(clk), .rst(rst),
    .va_grant_i(va_grant), .r_sa_i(r_sa), .tail_i(tail), .credit_i(credit),
    .g_sa_o(g_sa), .flit_valid_o(flit_valid), .vc_id_o(vc_id),
    .fifo_pointer_state_o(busy), .credit_err_o(credit_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      m_active[v] = 1'b0;
      m_drain[v]  = 1'b0;
      m_cred[v]   = D;
    end
    m_last    = N - 1;
    m_err     = 1'b0;
    m_lock    = 1'b0;
    m_lock_vc = 0;
  endtask

  function automatic bit model_elig(input int v, input logic [N-1:0] rs);
    return m_active[v] && rs[v] && (m_cred[v] > 0);
  endfunction

  function automatic int model_grant(input logic [N-1:0] rs);
    int v;
`ifdef NIC_LINK_SCHEDULER_PACKET_LOCK_EN
    if (m_lock) return model_elig(m_lock_vc, rs) ? m_lock_vc : -1;
`endif
    for (int k = 1; k <= N; k++) begin
      v = (m_last + k) % N;
      if (model_elig(v, rs)) return v;
    end
    return -1;
  endfunction

  task automatic compare_outputs();
    logic [N-1:0] eg, eb;
    exp_g = model_grant(r_sa);
    eg = (exp_g >= 0) ? (N'(1) << exp_g) : '0;
    for (int v = 0; v < N; v++) eb[v] = m_active[v] | m_drain[v];
    obs_g = g_sa; obs_busy = busy; obs_id = vc_id; obs_err = credit_err;
    chk("g_sa", 32'(g_sa), 32'(eg));
    chk("flit_valid", 32'(flit_valid), 32'(exp_g >= 0));
    chk("vc_id", 32'(vc_id), 32'((exp_g >= 0) ? exp_g : 0));
    chk("busy", 32'(busy), 32'(eb));
    chk("credit_err", 32'(credit_err), 32'(m_err));
  endtask

  task automatic model_update();
    for (int v = 0; v < N; v++) begin
      if (exp_g == v) m_cred[v]--;
      if (credit[v]) begin
        if (m_cred[v] == D) m_err = 1'b1;
        else m_cred[v]++;
      end
      if (!m_active[v] && !m_drain[v]) begin
        if (va_grant[v]) m_active[v] = 1'b1;
      end else if (m_active[v]) begin
        if (exp_g == v && tail[v]) begin
          m_active[v] = 1'b0;
          m_drain[v]  = 1'b1;
        end
      end else if (m_cred[v] == D) begin
        m_drain[v] = 1'b0;
      end
    end
    if (exp_g >= 0) begin
      m_last    = exp_g;
      m_lock    = !tail[exp_g];
      m_lock_vc = exp_g;
    end
  endtask

  // one clock cycle: drive, compare mid-cycle, advance model at the edge
  task automatic step(input logic [N-1:0] va, input logic [N-1:0] rs,
                      input logic [N-1:0] tl, input logic [N-1:0] cr);
    va_grant = va; r_sa = rs; tail = tl; credit = cr;
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    va_grant = '0; r_sa = '0; tail = '0; credit = '0;
    model_reset();
    #1;
    chk("rst_g_sa", 32'(g_sa), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(credit_err), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int seq [6];
    logic [N-1:0] va, rs, tl, cr;
    seq = '{0, 2, 5, 0, 2, 5};

    // single 4-flit packet on VC 0, then credits drain it back to FREE
    do_reset();
    step(6'b000001, '0, '0, '0);
    chk("busy0_active", 32'(obs_busy), 32'd0);
    for (int f = 0; f < 4; f++) begin
      step('0, 6'b000001, (f == 3) ? 6'b000001 : 6'b000000, '0);
      chk("pkt0_grant", 32'(obs_g), 32'h01);
    end
    step('0, 6'b000001, '0, '0);
    chk("pkt0_no_credit", 32'(obs_g), 32'h00);
    chk("pkt0_draining", 32'(obs_busy), 32'h01);
    for (int c = 0; c < 4; c++) begin
      step('0, '0, '0, 6'b000001);
      chk("pkt0_busy_wait", 32'(obs_busy), 32'h01);
    end
    step('0, '0, '0, '0);
    chk("pkt0_freed", 32'(obs_busy), 32'h00);

    // round robin across VCs 0, 2, 5
    do_reset();
    step(6'b100101, '0, '0, '0);
    for (int g = 0; g < 6; g++) begin
      step('0, 6'b100101, '0, '0);
      chk("rr_vc_id", 32'(obs_id), 32'(seq[g]));
    end

    // VC 1 out of credit: same-cycle return does not help, next cycle does
    do_reset();
    step(6'b000010, '0, '0, '0);
    for (int f = 0; f < 4; f++) step('0, 6'b000010, '0, '0);
    step('0, 6'b000010, '0, 6'b000010);
    chk("zero_credit_block", 32'(obs_g), 32'h00);
    step('0, 6'b000010, '0, '0);
    chk("credit_unblock", 32'(obs_g), 32'h02);

    // credit overflow on VC 3: sticky error, counter stays at depth
    do_reset();
    step('0, '0, '0, 6'b001000);
    chk("err_not_yet", 32'(obs_err), 32'd0);
    step(6'b001000, '0, '0, '0);
    chk("err_set", 32'(obs_err), 32'd1);
    for (int f = 0; f < 4; f++) begin
      step('0, 6'b001000, '0, '0);
      chk("ovf_credit_grant", 32'(obs_g), 32'h08);
    end
    step('0, 6'b001000, '0, '0);
    chk("ovf_credit_exhausted", 32'(obs_g), 32'h00);
    chk("err_sticky", 32'(obs_err), 32'd1);

    // 3-flit packet on VC 0 competing with VC 1
    do_reset();
    step(6'b000011, '0, '0, '0);
    for (int f = 0; f < 4; f++) begin
      step('0, 6'b000011, (f == 2) ? 6'b000001 : 6'b000000, '0);
`ifdef NIC_LINK_SCHEDULER_PACKET_LOCK_EN
      chk("lock_seq", 32'(obs_id), (f == 3) ? 32'd1 : 32'd0);
`else
      chk("interleave_seq", 32'(obs_id), 32'(f % 2));
`endif
    end

    // asynchronous reset in the middle of a packet
    do_reset();
    step(6'b000001, '0, '0, '0);
    step('0, 6'b000001, '0, '0);
    step('0, 6'b000001, '0, '0);
    r_sa = 6'b000001;
    #2;
    chk("pre_rst_grant", 32'(g_sa), 32'h01);
    rst = 1'b0;
    #1;
    chk("async_g_sa", 32'(g_sa), 32'd0);
    chk("async_valid", 32'(flit_valid), 32'd0);
    chk("async_vc_id", 32'(vc_id), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    model_reset();
    r_sa = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(6'b000001, 6'b000001, '0, '0);
    chk("post_rst_idle", 32'(obs_g), 32'h00);
    for (int f = 0; f < 4; f++) begin
      step('0, 6'b000001, '0, '0);
      chk("post_rst_credit", 32'(obs_g), 32'h01);
    end
    step('0, 6'b000001, '0, '0);
    chk("post_rst_exhausted", 32'(obs_g), 32'h00);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      for (int v = 0; v < N; v++) begin
        va[v] = ($urandom_range(0, 7) == 0);
        rs[v] = ($urandom_range(0, 9) < 7);
        tl[v] = ($urandom_range(0, 3) == 0);
        cr[v] = ($urandom_range(0, 9) < 3);
      end
      step(va, rs, tl, cr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nic_link_scheduler.md
NIC_LINK_SCHEDULER -- requirements
Module: nic_link_scheduler

Interface
REQ-001 SHALL have parameter N_TOT_OF_VC, default 6: number of downstream virtual channels (VN*VC).
REQ-002 SHALL have parameter N_BITS_VC_ID, default 3: width of the encoded VC id.
REQ-003 SHALL have parameter BUFFER_DEPTH, default 4: downstream flit slots per VC (initial credits).
REQ-004 SHALL have parameter N_BITS_CREDIT, default 3: credit counter width, able to hold BUFFER_DEPTH.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port va_grant_i, input, N_TOT_OF_VC: one-cycle pulse per VC, the VC was allocated to a packet by the VC allocator.
REQ-008 SHALL have port r_sa_i, input, N_TOT_OF_VC: bit i high means the out buffer owning VC i has a flit ready.
REQ-009 SHALL have port tail_i, input, N_TOT_OF_VC: bit i high means VC i's ready flit is a tail flit.
REQ-010 SHALL have port credit_i, input, N_TOT_OF_VC: one-cycle credit return pulse per VC.
REQ-011 SHALL have port g_sa_o, output, N_TOT_OF_VC: one-hot flit grant, at most one bit high.
REQ-012 SHALL have port flit_valid_o, output, 1: OR of g_sa_o.
REQ-013 SHALL have port vc_id_o, output, N_BITS_VC_ID: binary index of the granted VC, 0 when no grant.
REQ-014 SHALL have port fifo_pointer_state_o, output, N_TOT_OF_VC: bit i high means VC i busy (not FREE).
REQ-015 SHALL have port credit_err_o, output, 1: sticky credit overflow flag.

Function
REQ-016 SHALL keep per VC a 3-state FSM: FREE, ACTIVE, DRAINING.
REQ-017 SHALL move FREE->ACTIVE on va_grant_i[i]; va_grant_i[i] outside FREE SHALL be ignored.
REQ-018 SHALL move ACTIVE->DRAINING in the cycle after g_sa_o[i] is given with tail_i[i] high.
REQ-019 SHALL move DRAINING->FREE when credit counter i equals BUFFER_DEPTH, including a return arriving that same cycle (FREE visible next cycle).
REQ-020 SHALL treat VC i as eligible iff state ACTIVE, r_sa_i[i] high, credit counter i nonzero.
REQ-021 SHALL compute g_sa_o combinationally in the same cycle from registered state and current inputs, zero latency.
REQ-022 SHALL arbitrate round-robin: search starts at the VC after the last granted one, wrapping from N_TOT_OF_VC-1 to 0.
REQ-023 SHALL update the round-robin pointer only on a clock edge where a grant was issued.
REQ-024 SHALL decrement credit counter i on each grant to VC i and increment it on credit_i[i]; both in one cycle leave it unchanged.
REQ-025 SHALL ignore credit_i[i] when counter i is already BUFFER_DEPTH with no simultaneous grant, and set credit_err_o, held until reset.
REQ-026 SHALL never grant a VC whose counter is 0, even if a credit returns in that same cycle.

Reset
REQ-027 SHALL, while rst is low, asynchronously force: all VCs FREE, all counters BUFFER_DEPTH, RR pointer to VC N_TOT_OF_VC-1 (first search starts at VC 0), credit_err_o 0, lock flag cleared.
REQ-028 SHALL hold g_sa_o 0, flit_valid_o 0, vc_id_o 0, and fifo_pointer_state_o 0 during and right after reset.
REQ-029 SHALL abandon any packet in flight on reset mid-operation; no state survives reset.

Configuration
REQ-030 SHALL, with macro NIC_LINK_SCHEDULER_PACKET_LOCK_EN defined, lock arbitration after a non-tail grant: the locked VC is granted whenever eligible; others get no grant until the locked VC's tail is granted.
REQ-031 SHALL, without NIC_LINK_SCHEDULER_PACKET_LOCK_EN, arbitrate every flit independently per REQ-022, interleaving packets.

Verification
REQ-032 SHALL cover: reset, va_grant_i=6'b000001, r_sa_i[0]=1 with tail 4 flits later -> g_sa_o=000001 for 4 cycles, credits 4->0, busy[0]=1 until 4 credits return, then 0.
REQ-033 SHALL cover: VCs 0,2,5 ACTIVE and ready with full credits -> grant sequence 0,2,5,0,2,5 (vc_id_o 0,2,5,...) with lock macro undefined.
REQ-034 SHALL cover: VC 1 with credits 0 and r_sa_i[1]=1, credit_i[1] pulse -> no grant that cycle, grant next cycle.
REQ-035 SHALL cover: credit_i[3] pulse with VC 3 counter at 4 and no grant -> credit_err_o=1, counter stays 4.
REQ-036 SHALL cover: lock macro defined, VCs 0 and 1 ready, VC 0 sends a 3-flit packet -> grants 0,0,0 then 1.
REQ-037 SHALL cover: rst driven low mid-packet asynchronously -> outputs 0 immediately, busy all 0, counters 4 after release.
